// File: rtl/punct_pkg.sv
// Shared definitions for the 802.11a puncturer.
// Contents: rate codes, puncturing period per rate, and keep-mask constants.
// Keep masks are {keep_b, keep_a}.
package punct_pkg;

  typedef enum logic [1:0] {
    RATE_1_2  = 2'b00,
    RATE_2_3  = 2'b01,
    RATE_3_4  = 2'b10,
    RATE_RSVD = 2'b11
  } rate_e;

  // Number of input pairs in one puncturing period.
  localparam logic [1:0] PERIOD_1_2 = 2'd1;
  localparam logic [1:0] PERIOD_2_3 = 2'd2;
  localparam logic [1:0] PERIOD_3_4 = 2'd3;

  typedef struct packed {
    logic keep_b;
    logic keep_a;
  } keep_t;

  localparam keep_t KEEP_AB = 2'b11;
  localparam keep_t KEEP_A  = 2'b01;
  localparam keep_t KEEP_B  = 2'b10;

  // The reserved code behaves exactly like rate 1/2.
  function automatic rate_e norm_rate(input logic [1:0] r);
    return (r == 2'b11) ? RATE_1_2 : rate_e'(r);
  endfunction

  function automatic logic [1:0] rate_period(input rate_e r);
    case (r)
      RATE_2_3: return PERIOD_2_3;
      RATE_3_4: return PERIOD_3_4;
      default:  return PERIOD_1_2;
    endcase
  endfunction

endpackage

// File: rtl/punct_pattern.sv
// Combinational puncturing pattern lookup.
// Ports:
//   rate_i       - effective code rate for this pair
//   phase_i      - position of this pair within the puncturing period
//   keep_a_o     - bit A of the pair survives
//   keep_b_o     - bit B of the pair survives
//   last_phase_o - this pair closes the period (phase wraps to 0 next)
module punct_pattern
  import punct_pkg::*;
(
  input  rate_e      rate_i,
  input  logic [1:0] phase_i,
  output logic       keep_a_o,
  output logic       keep_b_o,
  output logic       last_phase_o
);

  keep_t keep;

  always_comb begin
    keep = KEEP_AB;
    case (rate_i)
      RATE_2_3: begin
        if (phase_i == 2'd1) keep = KEEP_A;
      end
      RATE_3_4: begin
        if (phase_i == 2'd1)      keep = KEEP_A;
        else if (phase_i == 2'd2) keep = KEEP_B;
      end
      default: keep = KEEP_AB;
    endcase
  end

  assign keep_a_o     = keep.keep_a;
  assign keep_b_o     = keep.keep_b;
  assign last_phase_o = (phase_i == (rate_period(rate_i) - 2'd1));

endmodule

// File: rtl/puncturer.sv
// 802.11a puncturer: takes rate-1/2 coded pairs (A,B), deletes bits according
// to the latched code rate and emits the survivors serially, A before B.
// Optional feature: define PUNCT_BITCOUNT_EN to add the per-frame output bit
// counter out_count_o (saturating, cleared by an accepted Sof beat).
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   rate_i                 - code rate, sampled only on an accepted Sof beat
//   in_valid_i/in_ready_o  - input handshake for in_a_i, in_b_i, sof_i
//   out_valid_o/out_ready_i- output handshake for out_bit_o
//   out_count_o            - bits emitted this frame (PUNCT_BITCOUNT_EN only)
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; valid never depends on ready, and a presented output is held stable
// until it is taken.
module puncturer
  import punct_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [1:0]             rate_i,
  input  logic                   in_valid_i,
  input  logic                   in_a_i,
  input  logic                   in_b_i,
  input  logic                   sof_i,
  output logic                   in_ready_o,
  output logic                   out_valid_o,
  output logic                   out_bit_o,
`ifdef PUNCT_BITCOUNT_EN
  output logic [COUNT_WIDTH-1:0] out_count_o,
`endif
  input  logic                   out_ready_i
);

  rate_e      rate_q, rate_d;
  logic [1:0] phase_q, phase_d;
  logic [1:0] pend_q, pend_d;   // bits held, including the one on out_bit_o
  logic [1:0] hold_q, hold_d;   // hold_q[0] is the bit currently presented
  logic       valid_q, valid_d;

  logic       pop;
  logic       accept;
  rate_e      pat_rate;
  logic [1:0] pat_phase;
  logic       keep_a, keep_b, last_phase;

  // A Sof pair always starts a new period at the newly presented rate.
  assign pat_rate  = sof_i ? norm_rate(rate_i) : rate_q;
  assign pat_phase = sof_i ? 2'd0 : phase_q;

  punct_pattern u_pattern (
    .rate_i      (pat_rate),
    .phase_i     (pat_phase),
    .keep_a_o    (keep_a),
    .keep_b_o    (keep_b),
    .last_phase_o(last_phase)
  );

  assign pop = valid_q & out_ready_i;

  // With one bit left and the sink taking it this cycle, the holding register
  // frees up at the same edge, so a new pair can be loaded without a bubble.
  assign in_ready_o = (pend_q == 2'd0) | ((pend_q == 2'd1) & out_ready_i);
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    rate_d  = rate_q;
    phase_d = phase_q;
    pend_d  = pend_q;
    hold_d  = hold_q;
    if (pop) begin
      hold_d = {1'b0, hold_q[1]};
      pend_d = pend_q - 2'd1;
    end
    if (accept) begin
      if (keep_a && keep_b) begin
        hold_d = {in_b_i, in_a_i};
        pend_d = 2'd2;
      end else if (keep_a) begin
        hold_d = {1'b0, in_a_i};
        pend_d = 2'd1;
      end else begin
        hold_d = {1'b0, in_b_i};
        pend_d = 2'd1;
      end
      phase_d = last_phase ? 2'd0 : pat_phase + 2'd1;
      if (sof_i) rate_d = pat_rate;
    end
    valid_d = (pend_d != 2'd0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rate_q  <= RATE_1_2;
      phase_q <= 2'd0;
      pend_q  <= 2'd0;
      hold_q  <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      rate_q  <= rate_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_bit_o   = hold_q[0];

`ifdef PUNCT_BITCOUNT_EN
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  // Clearing wins over counting so a frame boundary that coincides with the
  // previous frame's last bit starts the new frame at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && sof_i)     cnt_d = '0;
    else if (pop && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign out_count_o = cnt_q;
`else
  logic [COUNT_WIDTH-1:0] unused_count_w;
  assign unused_count_w = '0;
`endif

endmodule

// File: tb/tb_puncturer.sv
module tb_puncturer;
  import punct_pkg::*;

  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic [1:0]    rate;
  logic          in_valid;
  logic          in_a;
  logic          in_b;
  logic          sof;
  logic          in_ready;
  logic          out_valid;
  logic          out_bit;
  logic          out_ready;
  logic [CW-1:0] out_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  int         beat_cyc_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  puncturer #(.COUNT_WIDTH(CW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rate_i     (rate),
    .in_valid_i (in_valid),
    .in_a_i     (in_a),
    .in_b_i     (in_b),
    .sof_i      (sof),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_bit_o  (out_bit),
`ifdef PUNCT_BITCOUNT_EN
    .out_count_o(out_count),
`endif
    .out_ready_i(out_ready)
  );

`ifndef PUNCT_BITCOUNT_EN
  assign out_count = '0;
`endif

  // Output monitor: records every bit the sink takes and the cycle it did.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back(out_bit);
      beat_cyc_q.push_back(cyc);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_bit%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  // Beats must land on consecutive cycles (no bubbles).
  task automatic check_gapless(input string tag);
    if (beat_cyc_q.size() > 0)
      check({tag, "_gapless"}, beat_cyc_q[beat_cyc_q.size()-1] - beat_cyc_q[0],
            beat_cyc_q.size() - 1);
    else
      check({tag, "_gapless_nobeats"}, 0, 1);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    beat_cyc_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic send_pair(input logic a, input logic b, input logic s, input logic [1:0] r);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    sof      = s;
    rate     = r;
    #1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 50) check("send_timeout", 32'(waited), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sof      = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    @(negedge clk);
    while (out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("drain_timeout", 32'(waited), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 1'b0;
    in_b      = 1'b0;
    sof       = 1'b0;
    rate      = 2'b00;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_bit", 32'(out_bit), 0);
    check("reset_in_ready", 32'(in_ready), 1);
    check("reset_count", 32'(out_count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;

    // Rate 1/2
    clear_sb();
    exp_q = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    send_pair(1'b1, 1'b1, 1'b1, 2'b00);
    send_pair(1'b0, 1'b1, 1'b0, 2'b00);
    send_pair(1'b1, 1'b0, 1'b0, 2'b00);
    drain();
    check_stream("r12");
    check_gapless("r12");
`ifdef PUNCT_BITCOUNT_EN
    check("r12_count", 32'(out_count), 6);
`endif

    // Rate 3/4: A0 B0 A1 B2
    clear_sb();
    exp_q = '{1'b1, 1'b1, 1'b0, 1'b0};
    send_pair(1'b1, 1'b1, 1'b1, 2'b10);
    send_pair(1'b0, 1'b1, 1'b0, 2'b10);
    send_pair(1'b1, 1'b0, 1'b0, 2'b10);
    drain();
    check_stream("r34");
    check_gapless("r34");
`ifdef PUNCT_BITCOUNT_EN
    check("r34_count", 32'(out_count), 4);
`endif

    // Rate 2/3
    clear_sb();
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    send_pair(1'b1, 1'b0, 1'b1, 2'b01);
    send_pair(1'b1, 1'b1, 1'b0, 2'b01);
    send_pair(1'b0, 1'b1, 1'b0, 2'b01);
    send_pair(1'b0, 1'b0, 1'b0, 2'b01);
    drain();
    check_stream("r23");
`ifdef PUNCT_BITCOUNT_EN
    check("r23_count", 32'(out_count), 6);
`endif

    // Backpressure: sink stalls for 5 cycles with two bits held
    clear_sb();
    exp_q = '{1'b1, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b0;
    send_pair(1'b1, 1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_valid_%0d", i), 32'(out_valid), 1);
      check($sformatf("bp_bit_%0d", i), 32'(out_bit), 1);
      check($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    send_pair(1'b0, 1'b1, 1'b0, 2'b00);
    drain();
    check_stream("bp");
`ifdef PUNCT_BITCOUNT_EN
    check("bp_count", 32'(out_count), 4);
`endif

    // Sof resync from rate 3/4 phase 1 to rate 1/2; later rate change
    // without Sof must be ignored.
    clear_sb();
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    send_pair(1'b1, 1'b1, 1'b1, 2'b10);
    send_pair(1'b1, 1'b1, 1'b1, 2'b00);
    send_pair(1'b0, 1'b1, 1'b0, 2'b00);
    send_pair(1'b1, 1'b0, 1'b0, 2'b00);
    send_pair(1'b1, 1'b0, 1'b0, 2'b10);
    drain();
    check_stream("resync");
`ifdef PUNCT_BITCOUNT_EN
    check("resync_count", 32'(out_count), 8);
`endif

    // Async reset with two bits pending at rate 3/4
    out_ready = 1'b0;
    send_pair(1'b1, 1'b1, 1'b1, 2'b10);
    @(negedge clk);
    check("prerst_valid", 32'(out_valid), 1);
    check("prerst_in_ready", 32'(in_ready), 0);
    clear_sb();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_count", 32'(out_count), 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_residual", 32'(got_q.size()), 0);
    // Rate and phase must be back at 1/2, phase 0: pair is unpunctured.
    exp_q = '{1'b0, 1'b1};
    send_pair(1'b0, 1'b1, 1'b0, 2'b10);
    drain();
    check_stream("postrst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/puncturer.md
Name: puncturer

Overview:
- Rate-adaptation stage directly downstream of the rate-1/2, K=7 convolutional encoder in the 802.11a transmit chain.
- Accepts coded bit pairs (A,B) with a valid/ready handshake.
- Deletes bits per the 802.11a puncturing patterns for rates 1/2, 2/3 and 3/4.
- Emits the surviving bits serially, one per cycle, to the interleaver.

Parameters:
- COUNT_WIDTH, 16, width of the optional per-frame output bit counter.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Rate  input  2  code rate: 00 = 1/2, 01 = 2/3, 10 = 3/4, 11 = reserved, treated as 1/2. Sampled only on an Sof beat.
- InValid  input  1  InA/InB/Sof are valid this cycle.
- InA  input  1  encoder output A (g0 = 133 octal).
- InB  input  1  encoder output B (g1 = 171 octal).
- Sof  input  1  start of frame; qualified by InValid; marks the first pair of a frame.
- InReady  output  1  the block accepts a pair this cycle when InValid & InReady.
- OutValid  output  1  OutBit is valid.
- OutBit  output  1  punctured serial bit.
- OutReady  input  1  downstream accepts OutBit when OutValid & OutReady.
- OutCount  output  COUNT_WIDTH  bits emitted in the current frame. Present only with PUNCT_BITCOUNT_EN.

Behaviour:
- Reset (Reset=0, asynchronous): OutValid=0, OutBit=0, InReady=1, phase=0, latched rate=1/2, holding register empty, OutCount=0.
- Phase counter advances by 1 per accepted pair. It wraps at 1 (rate 1/2), 2 (rate 2/3) or 3 (rate 3/4).
- Keep mask per phase:
  - Rate 1/2: phase0 keeps AB.
  - Rate 2/3: phase0 keeps AB; phase1 keeps A only.
  - Rate 3/4: phase0 keeps AB; phase1 keeps A only; phase2 keeps B only.
- Every pair keeps at least one bit.
- Emission order within a pair is A before B. Rate 3/4 therefore emits A0 B0 A1 B2.
- Sof beat: the phase is forced to 0 for that pair, and Rate is latched. The latched rate holds until the next Sof.
- Accepting a pair:
  - The kept bits of the pair load into a 2-entry holding register with a pending count of 1 or 2.
  - The first kept bit appears on OutBit, with OutValid=1, in the cycle after the accept edge (1-cycle latency, registered outputs).
- On each OutValid & OutReady, the next pending bit is presented on the following cycle, or OutValid drops if none remain.
- InReady=1 when pending==0, or when pending==1 and OutReady=1 (bypass). This gives gap-free output when the downstream never stalls.
  - Rate 1/2 sustains 1 pair per 2 cycles.
  - Rate 3/4 averages 3 pairs per 4 cycles.
- Backpressure: while OutValid=1 and OutReady=0, OutBit and OutValid are held stable and pending is unchanged.
- InValid=0: no state change except draining the pending bits.
- Reset mid-pattern: all pending bits are discarded, and the phase and rate return to their reset values.
- A rate change without Sof is ignored.

Optional Feature:
- Macro: PUNCT_BITCOUNT_EN.
- When defined:
  - OutCount increments on every OutValid & OutReady.
  - OutCount clears to 0 on an accepted Sof beat. The Sof pair's first emitted bit counts as 1.
  - OutCount saturates at all-ones and does not wrap.
- When undefined: the OutCount port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package punct_pkg:
  - rate codes RATE_1_2, RATE_2_3, RATE_3_4;
  - pattern period per rate;
  - keep-mask constants.
- Sub-module punct_pattern: combinational (rate, phase) -> {keepA, keepB, last_phase}.
- The top level holds the handshake, holding register, phase counter and optional counter.

Test Plan:
- Rate 1/2: Sof with pairs (1,1),(0,1),(1,0); OutReady=1 -> OutBit 1,1,0,1,1,0 on 6 consecutive OutValid cycles; OutCount=6 at the end.
- Rate 3/4: Sof with pairs A=1,0,1 and B=1,1,0 -> OutBit 1,1,0,0 (A0 B0 A1 B2); exactly 4 valid beats.
- Rate 2/3: Sof with pairs (1,0),(1,1),(0,1),(0,0) -> OutBit 1,0,1,0,1,0.
- Backpressure: OutReady=0 for 5 cycles while OutValid=1 -> OutBit and OutValid stable, InReady=0 throughout, and no bit lost or duplicated after release.
- Sof resync: at rate 3/4 with the phase at 1, send a Sof pair (1,1) at Rate=00 -> output 1,1, and following pairs are unpunctured.
- Async reset: assert Reset=0 mid-pair with pending=2 -> OutValid=0 and InReady=1 immediately, no residual bit after release, and OutCount=0.
